// File: rtl/pci_master_wr_frontend.sv
// AXI4 write-slave front end for the PCI master write path: buffers burst beats
// in a circular word store, queues completed bursts as commands, returns B responses.
module pci_master_wr_frontend #(
  parameter int ID_W     = 4,
  parameter int BUF_AW   = 10,
  parameter int CQ_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ID_W-1:0]   s_awid,
  input  logic [63:0]       s_awaddr,
  input  logic [7:0]        s_awlen,
  input  logic              s_awvalid,
  output logic              s_awready,
  input  logic [31:0]       s_wdata,
  input  logic [3:0]        s_wstrb,
  input  logic              s_wlast,
  input  logic              s_wvalid,
  output logic              s_wready,
  output logic [ID_W-1:0]   s_bid,
  output logic [1:0]        s_bresp,
  output logic              s_bvalid,
  input  logic              s_bready,
  input  logic [BUF_AW-1:0] wdata_idx,
  output logic [31:0]       wdata_dout,
  output logic [3:0]        wdata_strb,
  output logic [ID_W-1:0]   wcmd_id,
  output logic [7:0]        wcmd_len,
  output logic [63:0]       wcmd_addr,
  output logic              wcmd_valid,
  input  logic              wcmd_ready,
  input  logic [ID_W-1:0]   wresp_id,
  input  logic [7:0]        wresp_len,
  input  logic [1:0]        wresp_err,
  input  logic              wresp_valid,
  output logic              wresp_ready,
  output logic              wlast_err
);

  localparam int DEPTH = 1 << BUF_AW;
  localparam int CQ_AW = (CQ_DEPTH > 1) ? $clog2(CQ_DEPTH) : 1;

  typedef enum logic {S_IDLE, S_DATA} state_t;

  state_t            state_q, state_d;
  logic [BUF_AW:0]   wptr, rptr;
  logic [BUF_AW+1:0] used, free;
  logic [8:0]        awlen_p1;
  logic              space_ok, cq_full;
  logic              aw_fire, w_fire, last_beat;
  logic              cq_push, cq_pop, wresp_fire;

  logic [35:0]       mem [DEPTH];

  logic [ID_W-1:0]   cur_id;
  logic [63:0]       cur_addr;
  logic [7:0]        cur_len, beat_cnt;

  logic [ID_W-1:0]   cq_id   [CQ_DEPTH];
  logic [7:0]        cq_len  [CQ_DEPTH];
  logic [63:0]       cq_addr [CQ_DEPTH];
  logic [CQ_AW-1:0]  cq_head, cq_tail;
  logic [CQ_AW:0]    cq_count;

  // Extra MSB on the pointers lets used reach DEPTH without aliasing to empty.
  always_comb begin
    used     = {1'b0, wptr - rptr};
    free     = (BUF_AW+2)'(DEPTH) - used;
    awlen_p1 = {1'b0, s_awlen} + 9'd1;
    space_ok = free >= (BUF_AW+2)'(awlen_p1);
    cq_full  = cq_count == (CQ_AW+1)'(CQ_DEPTH);
  end

  always_comb begin
    state_d   = state_q;
    s_awready = 1'b0;
    s_wready  = 1'b0;
    aw_fire   = 1'b0;
    w_fire    = 1'b0;
    last_beat = 1'b0;
    case (state_q)
      S_IDLE: begin
        s_awready = rst_n && space_ok && !cq_full;
        aw_fire   = s_awvalid && s_awready;
        if (aw_fire) state_d = S_DATA;
      end
      S_DATA: begin
        s_wready  = 1'b1;
        w_fire    = s_wvalid;
        last_beat = beat_cnt == cur_len;
        if (w_fire && last_beat) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cq_push     = w_fire && last_beat;
  assign wcmd_valid  = cq_count != '0;
  assign cq_pop      = wcmd_valid && wcmd_ready;
  assign wresp_ready = rst_n && !s_bvalid;
  assign wresp_fire  = wresp_valid && wresp_ready;

  assign wcmd_id    = cq_id[cq_head];
  assign wcmd_len   = cq_len[cq_head];
  assign wcmd_addr  = cq_addr[cq_head];
  assign wdata_dout = mem[wdata_idx][35:4];
  assign wdata_strb = mem[wdata_idx][3:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      wptr      <= '0;
      rptr      <= '0;
      cur_id    <= '0;
      cur_addr  <= '0;
      cur_len   <= '0;
      beat_cnt  <= '0;
      wlast_err <= 1'b0;
      cq_head   <= '0;
      cq_tail   <= '0;
      cq_count  <= '0;
      s_bvalid  <= 1'b0;
      s_bid     <= '0;
      s_bresp   <= '0;
    end else begin
      state_q <= state_d;
      if (aw_fire) begin
        cur_id   <= s_awid;
        cur_addr <= s_awaddr;
        cur_len  <= s_awlen;
        beat_cnt <= '0;
      end
      if (w_fire) begin
        wptr     <= wptr + 1'b1;
        beat_cnt <= beat_cnt + 1'b1;
        // Burst length follows awlen; a disagreeing wlast is only flagged.
        if (s_wlast != last_beat) wlast_err <= 1'b1;
      end
      if (cq_push) cq_tail <= (cq_tail == CQ_AW'(CQ_DEPTH-1)) ? '0 : cq_tail + 1'b1;
      if (cq_pop)  cq_head <= (cq_head == CQ_AW'(CQ_DEPTH-1)) ? '0 : cq_head + 1'b1;
      if (cq_push && !cq_pop)      cq_count <= cq_count + 1'b1;
      else if (cq_pop && !cq_push) cq_count <= cq_count - 1'b1;
      if (wresp_fire) begin
        s_bvalid <= 1'b1;
        s_bid    <= wresp_id;
        s_bresp  <= wresp_err;
        rptr     <= rptr + (BUF_AW+1)'(wresp_len) + (BUF_AW+1)'(1);
      end else if (s_bvalid && s_bready) begin
        s_bvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_fire) mem[wptr[BUF_AW-1:0]] <= {s_wdata, s_wstrb};
    if (cq_push) begin
      cq_id[cq_tail]   <= cur_id;
      cq_len[cq_tail]  <= cur_len;
      cq_addr[cq_tail] <= cur_addr;
    end
  end

endmodule

// File: tb/tb_pci_master_wr_frontend.sv
// Self-checking bench for pci_master_wr_frontend: directed scenarios plus a random
// burst/pop/retire phase against a word-count based reference model.
module tb_pci_master_wr_frontend;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  s_awid;
  logic [63:0] s_awaddr;
  logic [7:0]  s_awlen;
  logic        s_awvalid;
  logic        s_awready;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_wlast;
  logic        s_wvalid;
  logic        s_wready;
  logic [3:0]  s_bid;
  logic [1:0]  s_bresp;
  logic        s_bvalid;
  logic        s_bready;
  logic [9:0]  wdata_idx;
  logic [31:0] wdata_dout;
  logic [3:0]  wdata_strb;
  logic [3:0]  wcmd_id;
  logic [7:0]  wcmd_len;
  logic [63:0] wcmd_addr;
  logic        wcmd_valid;
  logic        wcmd_ready;
  logic [3:0]  wresp_id;
  logic [7:0]  wresp_len;
  logic [1:0]  wresp_err;
  logic        wresp_valid;
  logic        wresp_ready;
  logic        wlast_err;

  pci_master_wr_frontend #(.ID_W(4), .BUF_AW(10), .CQ_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen),
    .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .wdata_idx(wdata_idx), .wdata_dout(wdata_dout), .wdata_strb(wdata_strb),
    .wcmd_id(wcmd_id), .wcmd_len(wcmd_len), .wcmd_addr(wcmd_addr),
    .wcmd_valid(wcmd_valid), .wcmd_ready(wcmd_ready),
    .wresp_id(wresp_id), .wresp_len(wresp_len), .wresp_err(wresp_err),
    .wresp_valid(wresp_valid), .wresp_ready(wresp_ready),
    .wlast_err(wlast_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  id;
    logic [7:0]  len;
    logic [63:0] addr;
    int unsigned start;
  } cmd_t;

  // Reference model: beats written / words retired as plain counts.
  logic [35:0] mm [1024];
  int unsigned wcnt, rcnt;
  cmd_t        cmd_q[$];
  cmd_t        iss_q[$];
  logic        mb_valid;
  logic [3:0]  mb_id;
  logic [1:0]  mb_resp;
  logic        merr;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_can(input int unsigned len);
    return ((1024 - (wcnt - rcnt)) >= len + 1) && (cmd_q.size() < 4);
  endfunction

  task automatic chk_cmd();
    chk("wcmd_valid", wcmd_valid, cmd_q.size() != 0);
    if (cmd_q.size() != 0) begin
      chk("wcmd_id", wcmd_id, cmd_q[0].id);
      chk("wcmd_len", wcmd_len, cmd_q[0].len);
      chk("wcmd_addr", wcmd_addr, cmd_q[0].addr);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    s_awvalid = 0; s_wvalid = 0; s_wlast = 0; wcmd_ready = 0; wresp_valid = 0;
    wcnt = 0; rcnt = 0; cmd_q.delete(); iss_q.delete(); mb_valid = 0; merr = 0;
    #1;
    chk("rst_awready", s_awready, 1'b0);
    chk("rst_wready", s_wready, 1'b0);
    chk("rst_bvalid", s_bvalid, 1'b0);
    chk("rst_wcmd_valid", wcmd_valid, 1'b0);
    chk("rst_wresp_ready", wresp_ready, 1'b0);
    chk("rst_wlast_err", wlast_err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One AW (checked against model) and, if accepted, len+1 beats.
  task automatic aw_burst(input logic [3:0] id, input logic [63:0] addr, input int unsigned len,
                          input int early, input bit omit_last, input int base);
    logic        ok;
    logic [31:0] d;
    logic [3:0]  st;
    cmd_t        c;
    @(negedge clk);
    s_awid = id; s_awaddr = addr; s_awlen = 8'(len); s_awvalid = 1'b1;
    #1;
    ok = model_can(len);
    chk("awready", s_awready, ok);
    @(posedge clk);
    #1 s_awvalid = 1'b0;
    if (!ok) return;
    c.id = id; c.len = 8'(len); c.addr = addr; c.start = wcnt;
    for (int b = 0; b <= int'(len); b++) begin
      @(negedge clk);
      d  = (base >= 0) ? 32'(base + b) : $urandom;
      st = 4'($urandom);
      s_wdata = d; s_wstrb = st; s_wvalid = 1'b1;
      s_wlast = omit_last ? 1'b0 : ((b == int'(len)) || (b == early));
      #1;
      chk("wready", s_wready, 1'b1);
      chk("awready_in_data", s_awready, 1'b0);
      chk("wcmd_valid_mid", wcmd_valid, cmd_q.size() != 0);
      chk("wlast_err_mid", wlast_err, merr);
      @(posedge clk);
      mm[wcnt % 1024] = {d, st};
      wcnt++;
      if (s_wlast != (b == int'(len))) merr = 1'b1;
      #1 s_wvalid = 1'b0; s_wlast = 1'b0;
    end
    cmd_q.push_back(c);
    @(negedge clk);
    #1;
    chk("wready_after", s_wready, 1'b0);
    chk("wlast_err", wlast_err, merr);
    chk_cmd();
  endtask

  task automatic pop_cmd();
    @(negedge clk);
    wcmd_ready = 1'b1;
    #1 chk_cmd();
    @(posedge clk);
    iss_q.push_back(cmd_q.pop_front());
    #1 wcmd_ready = 1'b0;
  endtask

  task automatic send_wresp(input logic [3:0] id, input logic [7:0] len, input logic [1:0] err);
    @(negedge clk);
    wresp_id = id; wresp_len = len; wresp_err = err; wresp_valid = 1'b1;
    #1 chk("wresp_ready", wresp_ready, !mb_valid);
    @(posedge clk);
    rcnt += int'(len) + 1;
    mb_valid = 1'b1; mb_id = id; mb_resp = err;
    #1 wresp_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("bvalid", s_bvalid, mb_valid);
    chk("bid", s_bid, mb_id);
    chk("bresp", s_bresp, mb_resp);
    if (s_bready) begin
      @(posedge clk);
      mb_valid = 1'b0;
    end
  endtask

  task automatic retire_front(input logic [1:0] err);
    cmd_t c;
    c = iss_q.pop_front();
    send_wresp(c.id, c.len, err);
  endtask

  task automatic check_word(input int unsigned p);
    @(negedge clk);
    wdata_idx = 10'(p % 1024);
    #1;
    chk("buf_data", wdata_dout, mm[p % 1024][35:4]);
    chk("buf_strb", wdata_strb, mm[p % 1024][3:0]);
  endtask

  task automatic drain();
    while (cmd_q.size() != 0) pop_cmd();
    while (iss_q.size() != 0) retire_front(2'($urandom));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    cmd_t c;
    int   r;
    rst_n = 1'b0; s_awid = 0; s_awaddr = 0; s_awlen = 0; s_awvalid = 0;
    s_wdata = 0; s_wstrb = 0; s_wlast = 0; s_wvalid = 0; s_bready = 1'b1;
    wdata_idx = 0; wcmd_ready = 0; wresp_id = 0; wresp_len = 0; wresp_err = 0; wresp_valid = 0;
    merr = 0; mb_valid = 0; mb_id = 0; mb_resp = 0; wcnt = 0; rcnt = 0;

    // Basic burst
    do_reset();
    aw_burst(4'd3, 64'h1000, 3, -1, 1'b0, 'hA0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      wdata_idx = 10'(i);
      #1 chk("t1_data", wdata_dout, 32'hA0 + 32'(i));
    end
    pop_cmd();
    retire_front(2'd0);

    // Fill to 1024 words, then space freed by a retire opens AW next cycle
    do_reset();
    for (int i = 0; i < 4; i++) begin
      aw_burst(4'($urandom), {$urandom, $urandom}, 255, -1, 1'b0, -1);
      pop_cmd();
    end
    @(negedge clk);
    s_awlen = 8'd0; s_awvalid = 1'b1;
    c = iss_q.pop_front();
    wresp_id = c.id; wresp_len = c.len; wresp_err = 2'd1; wresp_valid = 1'b1;
    #1;
    chk("full_awready", s_awready, model_can(0));
    chk("full_wresp_ready", wresp_ready, 1'b1);
    @(posedge clk);
    rcnt += int'(c.len) + 1;
    #1 wresp_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("freed_awready", s_awready, model_can(0));
    chk("freed_bvalid", s_bvalid, 1'b1);
    chk("freed_bid", s_bid, c.id);
    s_awvalid = 1'b0;
    @(posedge clk);
    aw_burst(4'd7, 64'h20, 0, -1, 1'b0, -1);
    drain();

    // Pointer wrap
    do_reset();
    aw_burst(4'd1, 64'h0, 255, -1, 1'b0, -1); pop_cmd(); retire_front(2'd0);
    aw_burst(4'd1, 64'h0, 255, -1, 1'b0, -1); pop_cmd(); retire_front(2'd0);
    aw_burst(4'd1, 64'h0, 255, -1, 1'b0, -1); pop_cmd(); retire_front(2'd0);
    aw_burst(4'd1, 64'h0, 251, -1, 1'b0, -1); pop_cmd(); retire_front(2'd0);
    aw_burst(4'd9, 64'hFEED_0000, 7, -1, 1'b0, 'h50);
    for (int i = 0; i < 8; i++) check_word(1020 + i);
    @(negedge clk);
    wdata_idx = 10'd1;
    #1 chk("wrap_beat5", wdata_dout, 32'h55);
    drain();

    // Command queue full blocks AW until one pop
    do_reset();
    for (int i = 0; i < 4; i++) aw_burst(4'(i), 64'(i * 64), 0, -1, 1'b0, -1);
    aw_burst(4'd4, 64'h100, 0, -1, 1'b0, -1);
    @(negedge clk);
    s_awlen = 8'd0; s_awvalid = 1'b1; wcmd_ready = 1'b1;
    #1;
    chk("cqfull_awready", s_awready, model_can(0));
    chk_cmd();
    @(posedge clk);
    iss_q.push_back(cmd_q.pop_front());
    #1 wcmd_ready = 1'b0;
    @(negedge clk);
    #1 chk("cqpop_awready", s_awready, model_can(0));
    s_awvalid = 1'b0;
    @(posedge clk);
    aw_burst(4'd4, 64'h100, 0, -1, 1'b0, -1);
    drain();

    // wlast protocol errors
    do_reset();
    aw_burst(4'd2, 64'h40, 3, 1, 1'b0, -1);
    pop_cmd();
    retire_front(2'd0);
    do_reset();
    aw_burst(4'd6, 64'h80, 2, -1, 1'b1, -1);
    drain();
    do_reset();

    // B backpressure
    aw_burst(4'd5, 64'h0, 0, -1, 1'b0, -1); pop_cmd();
    aw_burst(4'd9, 64'h4, 0, -1, 1'b0, -1); pop_cmd();
    s_bready = 1'b0;
    @(negedge clk);
    wresp_id = 4'd5; wresp_len = 8'd0; wresp_err = 2'd2; wresp_valid = 1'b1;
    #1 chk("bp_ready0", wresp_ready, 1'b1);
    @(posedge clk);
    rcnt += 1;
    #1 wresp_id = 4'd9; wresp_err = 2'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("bp_bvalid", s_bvalid, 1'b1);
      chk("bp_bid", s_bid, 4'd5);
      chk("bp_bresp", s_bresp, 2'd2);
      chk("bp_hold", wresp_ready, 1'b0);
    end
    @(negedge clk);
    s_bready = 1'b1;
    #1 chk("bp_nobypass", wresp_ready, 1'b0);
    @(posedge clk);
    #1 s_bready = 1'b0;
    @(negedge clk);
    #1;
    chk("bp_cleared", s_bvalid, 1'b0);
    chk("bp_ready1", wresp_ready, 1'b1);
    @(posedge clk);
    rcnt += 1;
    #1 wresp_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("bp2_bvalid", s_bvalid, 1'b1);
    chk("bp2_bid", s_bid, 4'd9);
    chk("bp2_bresp", s_bresp, 2'd1);
    s_bready = 1'b1;
    @(posedge clk);
    mb_valid = 1'b0;
    iss_q.delete();

    // Random traffic
    do_reset();
    for (int it = 0; it < 80; it++) begin
      r = int'($urandom_range(0, 3));
      if (r <= 1) begin
        aw_burst(4'($urandom), {$urandom, $urandom},
                 ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 15),
                 -1, 1'b0, -1);
      end else if (r == 2 && cmd_q.size() != 0) begin
        pop_cmd();
      end else if (iss_q.size() != 0) begin
        c = iss_q[0];
        check_word(c.start);
        check_word(c.start + c.len);
        check_word(c.start + $urandom_range(0, int'(c.len)));
        retire_front(2'($urandom));
      end
    end
    drain();
    @(negedge clk);
    #1 chk("final_wcmd_valid", wcmd_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
